// File: rtl/uart_rx_assembler.sv
// ---------------------------------------------------------------------------
// uart_rx_assembler
//
// Rebuilds length-framed messages from the UART core's AXI-stream RX bytes.
// The first byte of a message is the payload length L (1..255), followed by
// L payload bytes. Payload bytes are packed MSB first into 16-bit words and
// buffered in a show-ahead FIFO; an odd final byte is padded with 8'h00.
// Only one message is buffered at a time: after a complete message the
// length byte of the next one is held off until the FIFO has been drained.
//
// Optional build macro:
//   RX_TIMEOUT_EN - abort a message whose bytes stop arriving for
//                   TIMEOUT_CYCLES clock cycles (ERROR pulse, FIFO flushed).
//
// Ports:
//   CLK              system clock
//   RST              asynchronous active-low reset
//   RX_DATA[7:0]     byte from UART core
//   RX_VALID         byte valid
//   RX_READY         byte accept (combinational, low only in DONE)
//   FIFO_RDREQ       pop one word (ignored while empty)
//   FIFO_Q[15:0]     head word, show-ahead
//   FIFO_EMPTY       FIFO holds no words
//   GOT_FULL_MESSAGE complete message buffered
//   MSG_LEN[7:0]     byte count of the last accepted message
//   PARITY_OUT       1 when MSG_LEN is odd
//   ERROR            one-cycle pulse on framing error / timeout
//   BUSY             reception in progress (state != WAIT_LEN)
//   state_mon[1:0]   current state: 0 WAIT_LEN, 1 GET_MSB, 2 GET_LSB, 3 DONE
// ---------------------------------------------------------------------------
module uart_rx_assembler #(
    parameter int FIFO_DEPTH     = 128,
    parameter int FIFO_AW        = 7,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    input  logic        FIFO_RDREQ,
    output logic [15:0] FIFO_Q,
    output logic        FIFO_EMPTY,
    output logic        GOT_FULL_MESSAGE,
    output logic [7:0]  MSG_LEN,
    output logic        PARITY_OUT,
    output logic        ERROR,
    output logic        BUSY,
    output logic [1:0]  state_mon
);

    typedef enum logic [1:0] {
        WAIT_LEN = 2'd0,
        GET_MSB  = 2'd1,
        GET_LSB  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        byte_cnt;
    logic [7:0]        byte_cnt_inc;
    logic [7:0]        hold;
    logic              accept;
    logic              timeout;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]  count;
    logic              wr_en;
    logic [15:0]       wr_data;
    logic              rd_en;

    function automatic logic [FIFO_AW-1:0] next_ptr(input logic [FIFO_AW-1:0] ptr);
        // Explicit wrap so non-power-of-two depths also work.
        if (ptr == FIFO_AW'(FIFO_DEPTH - 1))
            return '0;
        else
            return ptr + 1'b1;
    endfunction

    assign RX_READY     = (state != DONE);
    assign accept       = RX_VALID && RX_READY;
    assign byte_cnt_inc = byte_cnt + 8'd1;
    assign BUSY         = (state != WAIT_LEN);
    assign state_mon    = state;
    assign FIFO_EMPTY   = (count == '0);
    assign FIFO_Q       = mem[rd_ptr];
    assign rd_en        = FIFO_RDREQ && (count != '0);

    // A word is written when the low byte arrives, or when the high byte is
    // the last byte of an odd-length message (padded with zero).
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        if (accept) begin
            case (state)
                GET_MSB: begin
                    if (byte_cnt_inc == MSG_LEN) begin
                        wr_en   = 1'b1;
                        wr_data = {RX_DATA, 8'h00};
                    end
                end
                GET_LSB: begin
                    wr_en   = 1'b1;
                    wr_data = {hold, RX_DATA};
                end
                default: ;
            endcase
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IDLE_W-1:0] idle_cnt;
    logic              receiving;

    assign receiving = (state == GET_MSB) || (state == GET_LSB);
    // An accepted byte on the expiry cycle wins over the abort.
    assign timeout   = receiving && !accept &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            idle_cnt <= '0;
        else if (!receiving || accept || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // FIFO storage: data only, no reset.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (timeout) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= next_ptr(wr_ptr);
            if (rd_en)
                rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // High byte holding register: data only, no reset.
    always_ff @(posedge CLK) begin
        if (accept && (state == GET_MSB))
            hold <= RX_DATA;
    end

    // Framing state machine with registered status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state            <= WAIT_LEN;
            byte_cnt         <= 8'd0;
            MSG_LEN          <= 8'd0;
            PARITY_OUT       <= 1'b0;
            GOT_FULL_MESSAGE <= 1'b0;
            ERROR            <= 1'b0;
        end else begin
            ERROR <= 1'b0;
            if (timeout) begin
                state            <= WAIT_LEN;
                GOT_FULL_MESSAGE <= 1'b0;
                ERROR            <= 1'b1;
            end else begin
                case (state)
                    WAIT_LEN: begin
                        if (accept) begin
                            if (RX_DATA == 8'd0) begin
                                ERROR <= 1'b1;
                            end else begin
                                MSG_LEN    <= RX_DATA;
                                PARITY_OUT <= RX_DATA[0];
                                byte_cnt   <= 8'd0;
                                state      <= GET_MSB;
                            end
                        end
                    end
                    GET_MSB: begin
                        if (accept) begin
                            byte_cnt <= byte_cnt_inc;
                            if (byte_cnt_inc == MSG_LEN) begin
                                GOT_FULL_MESSAGE <= 1'b1;
                                state            <= DONE;
                            end else begin
                                state <= GET_LSB;
                            end
                        end
                    end
                    GET_LSB: begin
                        if (accept) begin
                            byte_cnt <= byte_cnt_inc;
                            if (byte_cnt_inc == MSG_LEN) begin
                                GOT_FULL_MESSAGE <= 1'b1;
                                state            <= DONE;
                            end else begin
                                state <= GET_MSB;
                            end
                        end
                    end
                    DONE: begin
                        // Hold off the next length byte until the consumer
                        // has drained the whole message.
                        if (count == '0) begin
                            GOT_FULL_MESSAGE <= 1'b0;
                            state            <= WAIT_LEN;
                        end
                    end
                    default: state <= WAIT_LEN;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_assembler.md
Name: uart_rx_assembler

Overview:
- Receive-side counterpart of the UART word transmitter: consumes bytes from the UART core's AXI-stream RX output and rebuilds length-framed messages of 16-bit words.
- Packs the bytes into 16-bit words and buffers them in an internal show-ahead FIFO.
- Reports message length and odd-byte parity to the downstream consumer, using the same MSG_LEN/PARITY semantics as the TX path.

Parameters:
- FIFO_DEPTH, 128, FIFO depth in 16-bit words; must be >= 128, the maximum message of 255 bytes.
- FIFO_AW, 7, FIFO address width; log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 50000, maximum idle CLK cycles between bytes inside a message; used only with RX_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- RX_DATA  in  8  byte from UART core (output_axis_tdata)
- RX_VALID  in  1  byte valid (output_axis_tvalid)
- RX_READY  out  1  byte accept (output_axis_tready)
- FIFO_RDREQ  in  1  pop one word
- FIFO_Q  out  16  head word, show-ahead
- FIFO_EMPTY  out  1  FIFO holds no words
- GOT_FULL_MESSAGE  out  1  complete message buffered
- MSG_LEN  out  8  byte count of the last accepted message
- PARITY_OUT  out  1  1 when MSG_LEN is odd
- ERROR  out  1  one-cycle pulse on framing error
- BUSY  out  1  reception in progress
- state_mon  out  2  current state, debug

Behaviour:
- Reset: CLK single clock; RST asynchronous, active-low.
  - Asserting RST forces state WAIT_LEN and empties the FIFO (pointers and count cleared).
  - Outputs after reset: MSG_LEN=0, PARITY_OUT=0, GOT_FULL_MESSAGE=0, ERROR=0, BUSY=0, FIFO_EMPTY=1.
  - Reset mid-message discards all partial data.
- Handshake: a byte is accepted on a rising CLK edge where RX_VALID && RX_READY.
  - RX_READY is combinational: 1 in WAIT_LEN, GET_MSB and GET_LSB; 0 in DONE.
- Framing: first byte is the length L (payload bytes), followed by L payload bytes.
  - Payload is packed MSB first: word = {byte 2k, byte 2k+1}.
  - For odd L, the final word is {last byte, 8'h00}.
- State WAIT_LEN:
  - Accepted byte 0: ERROR pulse, stay in WAIT_LEN, no FIFO write.
  - Accepted byte L != 0: latch MSG_LEN=L and PARITY_OUT=L[0], clear the payload byte counter, go to GET_MSB.
- State GET_MSB:
  - Accepted byte goes to a holding register; counter increments.
  - If this was byte L (odd L): write {byte, 8'h00} to the FIFO on this edge, set GOT_FULL_MESSAGE, go to DONE.
  - Otherwise go to GET_LSB.
- State GET_LSB:
  - Accepted byte: write {hold, byte} to the FIFO on this edge; counter increments.
  - Counter reaches L: set GOT_FULL_MESSAGE, go to DONE; otherwise go to GET_MSB.
- State DONE:
  - Stays until the FIFO is empty; then clears GOT_FULL_MESSAGE and returns to WAIT_LEN.
  - No new length byte is accepted until that point, so one message is buffered at a time and the FIFO cannot overflow.
- FIFO:
  - A written word is visible on FIFO_Q, with FIFO_EMPTY=0, the cycle after the write edge.
  - FIFO_RDREQ while empty is ignored.
  - Reads are allowed during reception.
  - Simultaneous read and write in the same cycle keeps the count unchanged.
- BUSY = (state != WAIT_LEN).
- MSG_LEN and PARITY_OUT hold their values until the next valid length byte.
- state_mon encoding: WAIT_LEN=0, GET_MSB=1, GET_LSB=2, DONE=3.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined: an idle counter is cleared on every accepted byte and counts in GET_MSB and GET_LSB.
  - Reaching TIMEOUT_CYCLES-1 triggers an abort: one-cycle ERROR pulse, FIFO flushed, GOT_FULL_MESSAGE=0, return to WAIT_LEN.
  - A byte accepted on the expiry cycle has priority and clears the counter.
- Undefined: no idle counter; GET_MSB and GET_LSB wait indefinitely; ERROR fires only for L=0.

Test Plan:
- Bytes 04 AA BB CC DD -> FIFO words AABB then CCDD; MSG_LEN=4, PARITY_OUT=0; GOT_FULL_MESSAGE set at the DD edge, cleared after the 2nd FIFO_RDREQ.
- Bytes 03 11 22 33 -> words 1122, 3300; MSG_LEN=3, PARITY_OUT=1.
- Byte 00 -> ERROR high exactly 1 cycle, FIFO_EMPTY stays 1, state stays WAIT_LEN; a following 01 5A -> word 5A00.
- Message 02 12 34 left unread, then next length 02 presented with RX_VALID held -> RX_READY=0 until the word 1234 is popped, then the byte is accepted.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: bytes 04 AA BB, then a 150-cycle gap -> ERROR pulse at idle count 99, FIFO_EMPTY=1; next message 02 01 02 -> word 0102.
- RST low after 04 AA -> BUSY=0, FIFO_EMPTY=1, GOT_FULL_MESSAGE=0; after release, 02 CA FE -> word CAFE.
